// File: rtl/sobol_rng_multidim.sv
// rtl/sobol_rng_multidim.sv - multi-dimension Sobol sequence generator with loadable direction vectors
module sobol_rng_multidim #(
    parameter int WIDTH = 8,
    parameter int DIM   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          restart,
    input  logic                          dv_we,
    input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] dv_dim,
    input  logic [$clog2(WIDTH)-1:0]      dv_idx,
    input  logic [WIDTH-1:0]              dv_data,
    output logic [DIM*WIDTH-1:0]          seq,
    output logic [WIDTH-1:0]              idx,
    output logic                          wrap
);
    localparam int DW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] x [DIM];
    logic [WIDTH-1:0] v [DIM][WIDTH];
    logic [IW-1:0]    c;

    // Lowest zero bit of n; an all-ones counter selects the top vector so x closes to 0 on wrap.
    always_comb begin
        c = IW'(WIDTH - 1);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!n[k]) begin
                c = IW'(k);
            end
        end
    end

    // Out-of-range dv_dim/dv_idx simply match no table entry, so they are dropped.
    always_ff @(posedge clk) begin
        for (int d = 0; d < DIM; d++) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (rst) begin
                    v[d][k] <= WIDTH'(1) << (WIDTH - 1 - k);
                end else if (dv_we && dv_dim == DW'(d) && dv_idx == IW'(k)) begin
                    v[d][k] <= dv_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            n    <= '0;
            wrap <= 1'b0;
            for (int d = 0; d < DIM; d++) begin
                x[d] <= '0;
            end
        end else if (enable) begin
            n    <= n + 1'b1;
            wrap <= &n;
            for (int d = 0; d < DIM; d++) begin
                x[d] <= x[d] ^ v[d][c];
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    always_comb begin
        seq = '0;
        for (int d = 0; d < DIM; d++) begin
            seq[d*WIDTH +: WIDTH] = x[d];
        end
    end

    assign idx = n;

endmodule

// File: tb/tb_sobol_rng_multidim.sv
// tb/tb_sobol_rng_multidim.sv - directed self-checking bench for sobol_rng_multidim
module tb_sobol_rng_multidim;
    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: WIDTH=3, DIM=3 (out-of-range dim/index codes are representable)
    logic       a_en = 0, a_rs = 0, a_we = 0;
    logic [1:0] a_dim = 0, a_idx = 0;
    logic [2:0] a_data = 0;
    logic [8:0] a_seq;
    logic [2:0] a_n;
    logic       a_wrap;

    // Instance B: WIDTH=8, DIM=2 defaults
    logic       b_en = 0;
    logic [15:0] b_seq;
    logic [7:0] b_n;
    logic       b_wrap;

    int n_vec = 0;
    int n_bad = 0;

    sobol_rng_multidim #(.WIDTH(3), .DIM(3)) u_a (
        .clk(clk), .rst(rst), .enable(a_en), .restart(a_rs),
        .dv_we(a_we), .dv_dim(a_dim), .dv_idx(a_idx), .dv_data(a_data),
        .seq(a_seq), .idx(a_n), .wrap(a_wrap)
    );

    sobol_rng_multidim #(.WIDTH(8), .DIM(2)) u_b (
        .clk(clk), .rst(rst), .enable(b_en), .restart(1'b0),
        .dv_we(1'b0), .dv_dim(1'b0), .dv_idx(3'd0), .dv_data(8'd0),
        .seq(b_seq), .idx(b_n), .wrap(b_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_step();
        a_en = 1'b1;
        tick();
        a_en = 1'b0;
    endtask

    task automatic a_wr(input logic [1:0] d, input logic [1:0] k, input logic [2:0] val);
        a_we = 1'b1; a_dim = d; a_idx = k; a_data = val;
        tick();
        a_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Default-vector Sobol value at index n is bit-reverse of gray(n)
    function automatic logic [7:0] vdc8(input int n);
        logic [7:0] g;
        logic [7:0] r;
        g = 8'(n ^ (n >> 1));
        for (int i = 0; i < 8; i++) r[i] = g[7-i];
        return r;
    endfunction

    logic [2:0] exp0 [9];
    logic [2:0] exp1 [9];
    int seen0 [256];
    int seen1 [256];
    int wraps;

    initial begin
        exp0 = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3, 3'd7, 3'd5, 3'd1, 3'd0};
        exp1 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd3, 3'd7, 3'd1, 3'd5, 3'd0};

        do_reset();
        check("rst_seq", 32'(a_seq), 0);
        check("rst_idx", 32'(a_n), 0);
        check("rst_wrap", 32'(a_wrap), 0);

        a_wr(2'd1, 2'd0, 3'd4);
        a_wr(2'd1, 2'd1, 3'd6);
        a_wr(2'd1, 2'd2, 3'd5);
        check("load_hold_idx", 32'(a_n), 0);

        for (int i = 1; i <= 8; i++) begin
            a_step();
            check($sformatf("per_d0_%0d", i), 32'(a_seq[2:0]), 32'(exp0[i]));
            check($sformatf("per_d1_%0d", i), 32'(a_seq[5:3]), 32'(exp1[i]));
            check($sformatf("per_d2_%0d", i), 32'(a_seq[8:6]), 32'(exp0[i]));
            check($sformatf("per_idx_%0d", i), 32'(a_n), 32'(i % 8));
            check($sformatf("per_wrap_%0d", i), 32'(a_wrap), (i == 8) ? 1 : 0);
        end
        tick();
        check("wrap_clear", 32'(a_wrap), 0);

        // Write v0[0]=1 during the step from n=0: old vector 4 applies
        a_we = 1'b1; a_dim = 2'd0; a_idx = 2'd0; a_data = 3'd1;
        a_step();
        a_we = 1'b0;
        check("wr_step_d0", 32'(a_seq[2:0]), 4);
        a_step();
        check("wr_n1_d0", 32'(a_seq[2:0]), 6);
        a_step();
        check("wr_newv_d0", 32'(a_seq[2:0]), 7);
        check("wr_newv_d1", 32'(a_seq[5:3]), 6);
        a_step();
        a_step();
        check("pre_rs_idx", 32'(a_n), 5);
        check("pre_rs_d0", 32'(a_seq[2:0]), 7);

        a_rs = 1'b1; a_en = 1'b1;
        tick();
        a_rs = 1'b0; a_en = 1'b0;
        check("rs_seq", 32'(a_seq), 0);
        check("rs_idx", 32'(a_n), 0);
        check("rs_wrap", 32'(a_wrap), 0);
        a_step();
        check("rs_keep_d0", 32'(a_seq[2:0]), 1);
        check("rs_keep_d1", 32'(a_seq[5:3]), 4);

        repeat (4) a_step();
        check("pre_rst_idx", 32'(a_n), 5);
        do_reset();
        check("rst2_idx", 32'(a_n), 0);
        a_step();
        check("rst_def_d0", 32'(a_seq[2:0]), 4);
        a_step();
        check("rst_def_d1", 32'(a_seq[5:3]), 6);

        do_reset();
        a_wr(2'd3, 2'd0, 3'd7);
        a_wr(2'd0, 2'd3, 3'd7);
        a_wr(2'd3, 2'd3, 3'd7);
        for (int i = 1; i <= 8; i++) begin
            a_step();
            check($sformatf("oor_d0_%0d", i), 32'(a_seq[2:0]), 32'(exp0[i]));
            check($sformatf("oor_d1_%0d", i), 32'(a_seq[5:3]), 32'(exp0[i]));
            check($sformatf("oor_d2_%0d", i), 32'(a_seq[8:6]), 32'(exp0[i]));
            if (i == 4) begin
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check($sformatf("hold_seq_%0d", h), 32'(a_seq[2:0]), 32'(exp0[4]));
                    check($sformatf("hold_idx_%0d", h), 32'(a_n), 4);
                end
            end
        end

        // Instance B: full 256-step period on defaults
        do_reset();
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            seen0[i] = 0;
            seen1[i] = 0;
        end
        b_en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            check($sformatf("b_d0_%0d", i), 32'(b_seq[7:0]), 32'(vdc8(i % 256)));
            check($sformatf("b_d1_%0d", i), 32'(b_seq[15:8]), 32'(vdc8(i % 256)));
            check($sformatf("b_wrap_%0d", i), 32'(b_wrap), (i == 256) ? 1 : 0);
            seen0[b_seq[7:0]]++;
            seen1[b_seq[15:8]]++;
            wraps += int'(b_wrap);
        end
        b_en = 1'b0;
        check("b_idx_end", 32'(b_n), 0);
        check("b_wraps", 32'(wraps), 1);
        for (int v = 0; v < 256; v++) begin
            if (seen0[v] != 1) check($sformatf("b_visit0_%0d", v), 32'(seen0[v]), 1);
            if (seen1[v] != 1) check($sformatf("b_visit1_%0d", v), 32'(seen1[v]), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sobol_rng_multidim.md
# sobol_rng_multidim

Parametrised multi-dimension Sobol low-discrepancy sequence generator for stochastic-computing bitstream generation. One shared index counter drives DIM independent Sobol dimensions, each with its own run-time-loadable direction-vector table. The sequence period is exactly 2^WIDTH. It sits in the RNG library in front of the comparators that convert binary operands into bitstreams.

## Interface
- WIDTH, 8, sequence/counter width in bits; legal 2..16
- DIM, 2, number of dimensions (output channels); legal 1..8
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- enable  input  1  advance all dimensions by one sequence step
- restart  input  1  synchronous sequence restart; direction vectors are kept
- dv_we  input  1  direction-vector write strobe
- dv_dim  input  $clog2(DIM) (min 1)  target dimension of the write
- dv_idx  input  $clog2(WIDTH)  target vector index k of the write
- dv_data  input  WIDTH  vector value written
- seq  output  DIM*WIDTH  current sequence values; dimension d at [d*WIDTH +: WIDTH]
- idx  output  WIDTH  current sequence index n (counter value)
- wrap  output  1  one-cycle pulse: sequence has just returned to index 0 by counting

## Operation
- State: counter n (WIDTH bits), per-dimension registers x_d (WIDTH bits), and vector tables v_d[0..WIDTH-1] (WIDTH bits each).
- Step, taken when enable=1 and restart=0:
  - c = index of the least-significant zero bit of n.
  - If n is all ones, c = WIDTH-1. This closes the period: x returns to 0 when n wraps to 0.
  - x_d <= x_d XOR v_d[c] for every d.
  - n <= n+1, modulo 2^WIDTH.
- enable=0: n and x_d hold.
- restart=1: n <= 0, all x_d <= 0, wrap <= 0. restart has priority over enable.
- Vector write: when dv_we=1, v_{dv_dim}[dv_idx] <= dv_data.
  - Writes with dv_dim >= DIM or dv_idx >= WIDTH are ignored, with no side effect.
  - A write is accepted regardless of enable and restart.
  - A step in the same cycle as a write uses the old vector value. The new value applies from the next cycle.
- Default vectors, loaded by reset only: v_d[k] = 1 << (WIDTH-1-k) for all d. This is the van der Corput / first Sobol dimension. Other dimensions are loaded by software.
- wrap <= 1 in the cycle after a step in which n was all ones; otherwise wrap <= 0.
- seq = concatenation of x_d; idx = n.

## Timing
- rst=1 at a clock edge sets n=0, all x_d=0, wrap=0, and all tables to defaults. rst overrides restart, enable and dv_we.
- Reset values of outputs: seq=0, idx=0, wrap=0.
- Latency: seq, idx and wrap are registered and change on the edge that samples enable=1. There is no combinational path from inputs to outputs.
- Throughput: one step per cycle with enable held high.
- Reset or restart mid-sequence discards progress immediately. The first step afterwards uses c=0.
- Vector tables are flops. The index-to-vector select is a combinational mux from n. No read latency.

## Test plan
- WIDTH=3, DIM=1, reset then enable held high 9 cycles -> seq = 0,4,6,2,3,7,5,1,0. idx = 0..7,0. wrap=1 only in the cycle seq returns to 0.
- WIDTH=8, DIM=2 defaults, 256 steps -> each dimension visits every value 0..255 exactly once. Both dimensions are identical. wrap pulses once, at step 256.
- WIDTH=3, dim 1 loaded v=[4,6,5] (Sobol dim 2), 8 steps -> dim 1 seq = 0,4,2,6,3,7,1,5. Dim 0 unchanged.
- Write v_0[0]=1 in the same cycle as a step from n=0 -> that step uses 4 (seq=4). The next step with c=0 uses 1.
- restart asserted at n=5 with enable=1 -> next cycle seq=0, idx=0, wrap=0, tables intact. rst at n=5 -> tables revert to defaults.
- Out-of-range write (dv_dim=DIM or dv_idx=WIDTH) followed by a full period -> sequence identical to the default sequence. enable=0 for 3 cycles mid-sequence -> seq and idx hold.
